// File: rtl/fixed_bias_add_pkg.sv
// Shared fixed-point helpers for the bias-add stream stage: fraction alignment,
// round-half-up with saturation, and width derivation for the common format.
package fixed_bias_add_pkg;

    // Working width for lane arithmetic inside the helpers.
    localparam int LANE_W = 64;

    function automatic int common_frac(input int frac_a, input int frac_b);
        return (frac_a > frac_b) ? frac_a : frac_b;
    endfunction

    // Integer bits of the wider operand, the common fraction, plus one carry bit.
    function automatic int sum_width(input int int_a, input int int_b, input int frac);
        return ((int_a > int_b) ? int_a : int_b) + frac + 1;
    endfunction

    function automatic logic signed [LANE_W-1:0] frac_align(
        input logic signed [LANE_W-1:0] v,
        input int                       shift
    );
        return v <<< shift;
    endfunction

    function automatic logic signed [LANE_W-1:0] round_sat(
        input logic signed [LANE_W-1:0] v,
        input int                       frac_in,
        input int                       frac_out,
        input int                       out_w
    );
        logic signed [LANE_W-1:0] r;
        logic signed [LANE_W-1:0] hi;
        logic signed [LANE_W-1:0] lo;
        if (frac_out < frac_in)
            r = (v + (64'sd1 <<< (frac_in - frac_out - 1))) >>> (frac_in - frac_out);
        else
            r = v <<< (frac_out - frac_in);
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready register slice: full throughput under backpressure,
// input ready never depends combinationally on out_ready.
module stream_skid_buffer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] main_data_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] skid_data_p1;
    logic             skid_vld_p1;
    logic             accept;
    logic             main_free;

    assign in_ready  = !skid_vld_p1;
    assign accept    = in_valid && in_ready;
    assign main_free = !vld_p1 || out_ready;

    // Stage p1: main feeds the output, skid catches the beat that arrives while main stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            skid_vld_p1  <= 1'b0;
            main_data_p1 <= '0;
            skid_data_p1 <= '0;
        end else if (main_free) begin
            if (skid_vld_p1) begin
                main_data_p1 <= skid_data_p1;
                vld_p1       <= 1'b1;
                skid_vld_p1  <= 1'b0;
            end else if (accept) begin
                main_data_p1 <= in_data;
                vld_p1       <= 1'b1;
            end else begin
                vld_p1       <= 1'b0;
            end
        end else if (accept) begin
            skid_data_p1 <= in_data;
            skid_vld_p1  <= 1'b1;
        end
    end

    assign out_data  = main_data_p1;
    assign out_valid = vld_p1;

endmodule

// File: rtl/fixed_bias_add_stream.sv
// Joins an activation stream with a bias stream, adds lane-wise in fixed point,
// rounds/saturates to the output format and tags the last beat of each row.
module fixed_bias_add_stream
    import fixed_bias_add_pkg::*;
#(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int DATA_IN_PRECISION_1  = 3,
    parameter int BIAS_PRECISION_0     = 16,
    parameter int BIAS_PRECISION_1     = 3,
    parameter int DATA_OUT_PRECISION_0 = 16,
    parameter int DATA_OUT_PRECISION_1 = 3,
    parameter int TENSOR_SIZE_DIM_0    = 32,
    parameter int PARALLELISM_DIM_0    = 1,
    parameter int PARALLELISM_DIM_1    = 1,
    parameter int OUT_DEPTH            = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    localparam int N                   = PARALLELISM_DIM_0 * PARALLELISM_DIM_1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N-1:0][DATA_IN_PRECISION_0-1:0]  data_in,
    input  logic                                  data_in_valid,
    output logic                                  data_in_ready,
    input  logic [N-1:0][BIAS_PRECISION_0-1:0]     bias,
    input  logic                                  bias_valid,
    output logic                                  bias_ready,
    output logic [N-1:0][DATA_OUT_PRECISION_0-1:0] data_out,
    output logic                                  data_out_valid,
    input  logic                                  data_out_ready,
    output logic                                  data_out_last
);

    localparam int F         = common_frac(DATA_IN_PRECISION_1, BIAS_PRECISION_1);
    localparam int SUM_W     = sum_width(DATA_IN_PRECISION_0 - DATA_IN_PRECISION_1,
                                         BIAS_PRECISION_0 - BIAS_PRECISION_1, F);
    localparam int PAYLOAD_W = N * DATA_OUT_PRECISION_0 + 1;
    localparam int CNT_W     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic                                  can_accept;
    logic                                  vld_p0;
    logic                                  accept_p0;
    logic                                  last_p0;
    logic [N-1:0][DATA_OUT_PRECISION_0-1:0] res_p0;
    logic [PAYLOAD_W-1:0]                  payload_p1;
    logic [CNT_W-1:0]                      beat_cnt;

    assign vld_p0        = data_in_valid && bias_valid;
    assign data_in_ready = can_accept && bias_valid;
    assign bias_ready    = can_accept && data_in_valid;
    assign accept_p0     = vld_p0 && can_accept;

    // Stage p0: align fractions, add, then round and saturate into the output format.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [SUM_W-1:0] sum_p0;
        assign sum_p0 = SUM_W'(
            frac_align(LANE_W'($signed(data_in[i])), F - DATA_IN_PRECISION_1) +
            frac_align(LANE_W'($signed(bias[i])),    F - BIAS_PRECISION_1));
        assign res_p0[i] = DATA_OUT_PRECISION_0'(
            round_sat(LANE_W'(sum_p0), F, DATA_OUT_PRECISION_1, DATA_OUT_PRECISION_0));
    end

    assign last_p0 = (beat_cnt == CNT_W'(OUT_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst)
            beat_cnt <= '0;
        else if (accept_p0)
            beat_cnt <= last_p0 ? '0 : beat_cnt + CNT_W'(1);
    end

    // Stage p1: result and its row tag travel together through the skid buffer.
    stream_skid_buffer #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({last_p0, res_p0}),
        .in_valid (vld_p0),
        .in_ready (can_accept),
        .out_data (payload_p1),
        .out_valid(data_out_valid),
        .out_ready(data_out_ready)
    );

    assign {data_out_last, data_out} = payload_p1;

endmodule
